// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and counter sizing.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } md_state_t;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  function automatic logic md_is_mul(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return !((op == MD_MULTU) || (op == MD_DIVU));
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring radix-2 magnitude divider, one quotient bit per cycle.
// Optional early-exit hook enabled by MULDIV_DIV_EARLY_EXIT_EN.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CW    = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_skip,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quo_next,
  output logic [WIDTH-1:0] o_rem_next
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_run;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_bit;

  // The dividend shifts out of r_quo MSB-first while quotient bits shift in.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_bit      = ~w_diff[WIDTH];
  assign o_rem_next = w_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo_next = {r_quo[WIDTH-2:0], w_bit};
  assign o_last     = r_run && (r_cnt == '0);

`ifdef MULDIV_DIV_EARLY_EXIT_EN
  assign o_skip = (i_divisor == '0) || (i_dividend < i_divisor);
`else
  assign o_skip = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_clear) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_div <= i_divisor;
      r_cnt <= CW'(WIDTH - 1);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_quo <= o_quo_next;
      r_rem <= o_rem_next;
      if (r_cnt == '0) begin
        r_run <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with valid/ready handshake and annul.
// Divide early exit is enabled by defining MULDIV_DIV_EARLY_EXIT_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               annul,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               div_by_zero
);

  localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam int CW  = $clog2(WIDTH);

  md_state_t          r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_result;
  logic               r_out_valid;
  logic               r_dbz;
  logic [MCW-1:0]     r_mul_cnt;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_skip;
  logic               w_last;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_q_neg;
  logic               w_r_neg;
  logic [2*WIDTH-1:0] w_div_res;
  logic [2*WIDTH-1:0] w_skip_res;
  logic [2*WIDTH-1:0] w_mul_now;
  logic [2*WIDTH-1:0] w_mul_lat;
  logic [2*WIDTH-1:0] w_mul_out;

  // Low 2*WIDTH bits of the extended product give the signed or unsigned result.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic sgn,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  assign in_ready    = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

  assign w_accept = in_valid && (r_state == ST_IDLE) && !annul;

  // Most-negative operand negates to itself, which is its correct unsigned magnitude.
  assign w_a_neg = md_is_signed(op) & a[WIDTH-1];
  assign w_b_neg = md_is_signed(op) & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

  muldiv_div_core #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_div_core (
    .clk        (clk),
    .rst_n      (rst),
    .i_start    (w_accept && md_is_div(op) && !w_skip),
    .i_clear    (annul),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_skip     (w_skip),
    .o_last     (w_last),
    .o_quo_next (w_quo_mag),
    .o_rem_next (w_rem_mag)
  );

  assign w_q_neg   = md_is_signed(r_op) & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_r_neg   = md_is_signed(r_op) & r_a[WIDTH-1];
  assign w_quo     = w_q_neg ? (~w_quo_mag + 1'b1) : w_quo_mag;
  assign w_rem     = w_r_neg ? (~w_rem_mag + 1'b1) : w_rem_mag;
  assign w_div_res = (r_b == '0) ? {r_a, {WIDTH{1'b1}}} : {w_rem, w_quo};
  assign w_skip_res = (b == '0) ? {a, {WIDTH{1'b1}}} : {a, {WIDTH{1'b0}}};

  assign w_mul_now = mul_full(md_is_signed(op), a, b);
  assign w_mul_lat = mul_full(md_is_signed(r_op), r_a, r_b);

  generate
    if (MUL_LAT >= 3) begin : g_mul_pipe
      logic [2*WIDTH-1:0] r_pipe [MUL_LAT-2];
      // NOTE: the product delay line has no reset; out_valid alone qualifies it,
      // so clearing these data registers would only cost reset routing.
      always_ff @(posedge clk) begin
        r_pipe[0] <= w_mul_lat;
        for (int i = 1; i < MUL_LAT - 2; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_mul_out = r_pipe[MUL_LAT-3];
    end else begin : g_mul_direct
      assign w_mul_out = w_mul_lat;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_op        <= MD_MULT;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
      r_mul_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
            if (md_is_div(op)) begin
              if (w_skip) begin
                r_result    <= w_skip_res;
                r_dbz       <= (b == '0);
                r_out_valid <= 1'b1;
                r_state     <= ST_DONE;
              end else begin
                r_state <= ST_DIV;
              end
            end else if (MUL_LAT == 1) begin
              r_result    <= w_mul_now;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_mul_cnt <= MCW'((MUL_LAT >= 2) ? MUL_LAT - 2 : 0);
              r_state   <= ST_MUL;
            end
          end
        end

        ST_MUL: begin
          if (annul) begin
            r_state <= ST_IDLE;
          end else if (r_mul_cnt == '0) begin
            r_result    <= w_mul_out;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
          end
        end

        ST_DIV: begin
          if (annul) begin
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_result    <= w_div_res;
            r_dbz       <= (r_b == '0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (annul || out_ready) begin
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
